// File: rtl/npu_if_pkg.sv
// npu_if_pkg
// Shared constants for the CPU<->NPU queue bank: the default data width, the default
// queue depths and the bit positions inside the sticky error vector.
package npu_if_pkg;

    localparam int unsigned NPU_DATA_W    = 32;
    localparam int unsigned NPU_CFG_DEPTH = 8;
    localparam int unsigned NPU_IN_DEPTH  = 16;
    localparam int unsigned NPU_OUT_DEPTH = 16;

    // Sticky error vector layout
    localparam int unsigned NPU_ERR_W        = 3;
    localparam int unsigned NPU_ERR_PUSH_BIT = 0;  // push seen while full
    localparam int unsigned NPU_ERR_POP_BIT  = 1;  // pop seen while empty
    localparam int unsigned NPU_ERR_RSVD_BIT = 2;  // reserved, always 0

endpackage

// File: rtl/npu_sync_fifo.sv
// npu_sync_fifo
// Single-clock first-word-fall-through FIFO with registered full/empty flags.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset (pointers and flags only)
//   push       in   write request
//   push_data  in   word to write
//   pop        in   read request (advances head)
//   head_data  out  word at the read pointer; meaningless while empty
//   full       out  registered full flag
//   empty      out  registered empty flag
//   ovf        out  pulse: push requested while full (push dropped)
//   udf        out  pulse: pop requested while empty (pop dropped)
module npu_sync_fifo
    import npu_if_pkg::*;
#(
    parameter int unsigned DATA_W = NPU_DATA_W,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              udf
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]       wr_q, wr_d;
    logic [AW:0]       rd_q, rd_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic push_ok;
    logic pop_ok;

    // Acceptance uses the current registered flags, so at full a simultaneous
    // push is dropped and at empty a simultaneous pop is dropped.
    always_comb begin
        push_ok = push & ~full_q;
        pop_ok  = pop & ~empty_q;
        ovf     = push & full_q;
        udf     = pop & empty_q;
    end

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok) begin
            wr_d = wr_q + {{AW{1'b0}}, 1'b1};
        end
        if (pop_ok) begin
            rd_d = rd_q + {{AW{1'b0}}, 1'b1};
        end
        full_d  = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
        empty_d = (wr_d == rd_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage is not reset; the write is suppressed during reset.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem[wr_q[AW-1:0]] <= push_data;
        end
    end

    always_comb begin
        head_data = mem[rd_q[AW-1:0]];
        full      = full_q;
        empty     = empty_q;
    end

endmodule

// File: rtl/npu_queue_interface.sv
// npu_queue_interface
// CPU<->NPU queue bank. The CPU pushes into the config and input queues and pops the
// output queue; the NPU pops config/input and pushes results. Full/empty flags feed
// the EX-stage stall logic, so any dropped push/pop indicates a pipeline bug and is
// latched in a sticky error vector until reset.
// Ports:
//   iClk, iRst_n                     clock, synchronous active-low reset
//   iCfgEnq/iCfgData, oCfgFull       CPU side of the config queue
//   iInEnq/iInData, oInFull          CPU side of the input queue
//   iOutDeq, oOutData, oOutEmpty     CPU side of the output queue
//   oNpuCfgValid/oNpuCfgData, iNpuCfgRd  NPU side of the config queue
//   oNpuInValid/oNpuInData, iNpuInRd     NPU side of the input queue
//   iNpuOutWr/iNpuOutData, oNpuOutFull   NPU side of the output queue
//   oErr                             sticky [0] push-on-full, [1] pop-on-empty, [2] zero
module npu_queue_interface
    import npu_if_pkg::*;
#(
    parameter int unsigned DATA_W    = NPU_DATA_W,
    parameter int unsigned CFG_DEPTH = NPU_CFG_DEPTH,
    parameter int unsigned IN_DEPTH  = NPU_IN_DEPTH,
    parameter int unsigned OUT_DEPTH = NPU_OUT_DEPTH
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iCfgEnq,
    input  logic [DATA_W-1:0]    iCfgData,
    output logic                 oCfgFull,
    input  logic                 iInEnq,
    input  logic [DATA_W-1:0]    iInData,
    output logic                 oInFull,
    input  logic                 iOutDeq,
    output logic [DATA_W-1:0]    oOutData,
    output logic                 oOutEmpty,
    output logic                 oNpuCfgValid,
    output logic [DATA_W-1:0]    oNpuCfgData,
    input  logic                 iNpuCfgRd,
    output logic                 oNpuInValid,
    output logic [DATA_W-1:0]    oNpuInData,
    input  logic                 iNpuInRd,
    input  logic                 iNpuOutWr,
    input  logic [DATA_W-1:0]    iNpuOutData,
    output logic                 oNpuOutFull,
    output logic [NPU_ERR_W-1:0] oErr
);

    logic cfg_empty, cfg_ovf, cfg_udf;
    logic in_empty, in_ovf, in_udf;
    logic out_full, out_ovf, out_udf;

    logic [NPU_ERR_W-1:0] err_q;

    npu_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (CFG_DEPTH)
    ) u_cfg_fifo (
        .clk       (iClk),
        .rst_n     (iRst_n),
        .push      (iCfgEnq),
        .push_data (iCfgData),
        .pop       (iNpuCfgRd),
        .head_data (oNpuCfgData),
        .full      (oCfgFull),
        .empty     (cfg_empty),
        .ovf       (cfg_ovf),
        .udf       (cfg_udf)
    );

    npu_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (IN_DEPTH)
    ) u_in_fifo (
        .clk       (iClk),
        .rst_n     (iRst_n),
        .push      (iInEnq),
        .push_data (iInData),
        .pop       (iNpuInRd),
        .head_data (oNpuInData),
        .full      (oInFull),
        .empty     (in_empty),
        .ovf       (in_ovf),
        .udf       (in_udf)
    );

    npu_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (iClk),
        .rst_n     (iRst_n),
        .push      (iNpuOutWr),
        .push_data (iNpuOutData),
        .pop       (iOutDeq),
        .head_data (oOutData),
        .full      (out_full),
        .empty     (oOutEmpty),
        .ovf       (out_ovf),
        .udf       (out_udf)
    );

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            err_q <= '0;
        end else begin
            err_q[NPU_ERR_PUSH_BIT] <= err_q[NPU_ERR_PUSH_BIT] | cfg_ovf | in_ovf | out_ovf;
            err_q[NPU_ERR_POP_BIT]  <= err_q[NPU_ERR_POP_BIT] | cfg_udf | in_udf | out_udf;
            err_q[NPU_ERR_RSVD_BIT] <= 1'b0;
        end
    end

    always_comb begin
        oNpuCfgValid = ~cfg_empty;
        oNpuInValid  = ~in_empty;
        oNpuOutFull  = out_full;
        oErr         = err_q;
    end

endmodule

// File: tb/tb_npu_queue_interface.sv
module tb_npu_queue_interface;

    localparam int unsigned DW   = 32;
    localparam int unsigned CFGD = 8;
    localparam int unsigned IND  = 16;
    localparam int unsigned OUTD = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_enq, in_enq, out_deq, npu_cfg_rd, npu_in_rd, npu_out_wr;
    logic [DW-1:0] cfg_data, in_data, npu_out_data;
    logic          cfg_full, in_full, out_empty, npu_cfg_valid, npu_in_valid, npu_out_full;
    logic [DW-1:0] out_data, npu_cfg_data, npu_in_data;
    logic [2:0]    err;

    always #5 clk = ~clk;

    npu_queue_interface dut (
        .iClk         (clk),
        .iRst_n       (rst_n),
        .iCfgEnq      (cfg_enq),
        .iCfgData     (cfg_data),
        .oCfgFull     (cfg_full),
        .iInEnq       (in_enq),
        .iInData      (in_data),
        .oInFull      (in_full),
        .iOutDeq      (out_deq),
        .oOutData     (out_data),
        .oOutEmpty    (out_empty),
        .oNpuCfgValid (npu_cfg_valid),
        .oNpuCfgData  (npu_cfg_data),
        .iNpuCfgRd    (npu_cfg_rd),
        .oNpuInValid  (npu_in_valid),
        .oNpuInData   (npu_in_data),
        .iNpuInRd     (npu_in_rd),
        .iNpuOutWr    (npu_out_wr),
        .iNpuOutData  (npu_out_data),
        .oNpuOutFull  (npu_out_full),
        .oErr         (err)
    );

    // Reference model: one queue per FIFO plus the sticky error bits.
    logic [DW-1:0] cfg_m[$];
    logic [DW-1:0] in_m[$];
    logic [DW-1:0] out_m[$];
    logic [2:0]    err_m;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        cfg_enq = 0; in_enq = 0; out_deq = 0; npu_cfg_rd = 0; npu_in_rd = 0; npu_out_wr = 0;
        cfg_data = '0; in_data = '0; npu_out_data = '0;
    endtask

    // Apply one FIFO's request to its model queue using occupancy before the edge.
    task automatic model_fifo(inout logic [DW-1:0] q[$], input int unsigned depth,
                              input logic push, input logic [DW-1:0] d, input logic pop);
        bit is_full, is_empty;
        is_full  = (q.size() == depth);
        is_empty = (q.size() == 0);
        if (push && is_full)   err_m[0] = 1'b1;
        if (pop && is_empty)   err_m[1] = 1'b1;
        if (pop && !is_empty)  void'(q.pop_front());
        if (push && !is_full)  q.push_back(d);
    endtask

    task automatic check_state(input string where);
        check_eq({where, ":cfg_full"},  {31'd0, cfg_full},      {31'd0, cfg_m.size() == CFGD});
        check_eq({where, ":cfg_valid"}, {31'd0, npu_cfg_valid}, {31'd0, cfg_m.size() != 0});
        check_eq({where, ":in_full"},   {31'd0, in_full},       {31'd0, in_m.size() == IND});
        check_eq({where, ":in_valid"},  {31'd0, npu_in_valid},  {31'd0, in_m.size() != 0});
        check_eq({where, ":out_full"},  {31'd0, npu_out_full},  {31'd0, out_m.size() == OUTD});
        check_eq({where, ":out_empty"}, {31'd0, out_empty},     {31'd0, out_m.size() == 0});
        check_eq({where, ":err"},       {29'd0, err},           {29'd0, err_m});
        if (cfg_m.size() != 0) check_eq({where, ":cfg_head"}, npu_cfg_data, cfg_m[0]);
        if (in_m.size() != 0)  check_eq({where, ":in_head"},  npu_in_data,  in_m[0]);
        if (out_m.size() != 0) check_eq({where, ":out_head"}, out_data,     out_m[0]);
    endtask

    // One clock: update the model from the driven inputs, clock, then compare #1 later.
    task automatic cycle(input string where);
        if (!rst_n) begin
            cfg_m.delete(); in_m.delete(); out_m.delete();
            err_m = '0;
        end else begin
            model_fifo(cfg_m, CFGD, cfg_enq, cfg_data, npu_cfg_rd);
            model_fifo(in_m, IND, in_enq, in_data, npu_in_rd);
            model_fifo(out_m, OUTD, npu_out_wr, npu_out_data, out_deq);
        end
        @(posedge clk);
        #1;
        check_state(where);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        cycle("rst");
        rst_n = 1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        err_m = '0;
        @(negedge clk);
        cycle("rst0");
        rst_n = 1;

        // 1: reset in the middle of traffic on every queue
        for (int i = 0; i < 5; i++) begin
            cfg_enq = 1; cfg_data = 32'hA0 + i;
            in_enq = 1; in_data = 32'hB0 + i;
            npu_out_wr = 1; npu_out_data = 32'hD0 + i;
            cycle("t1_fill");
        end
        npu_cfg_rd = 1; out_deq = 1;   // requests present during the reset cycle
        rst_n = 0;
        cycle("t1_rst");
        rst_n = 1;
        idle_inputs();
        check_eq("t1_cfg_valid", {31'd0, npu_cfg_valid}, 32'd0);
        check_eq("t1_in_valid",  {31'd0, npu_in_valid},  32'd0);
        check_eq("t1_out_empty", {31'd0, out_empty},     32'd1);
        check_eq("t1_out_full",  {31'd0, npu_out_full},  32'd0);
        check_eq("t1_err",       {29'd0, err},           32'd0);

        // 2: fill config queue, overflow, drain in order
        for (int i = 0; i < 8; i++) begin
            cfg_enq = 1; cfg_data = 32'hC0 + i;
            cycle("t2_push");
        end
        check_eq("t2_full", {31'd0, cfg_full}, 32'd1);
        cfg_data = 32'hC8;
        cycle("t2_ovf");
        cfg_enq = 0;
        check_eq("t2_err0", {29'd0, err}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            check_eq("t2_pop_data", npu_cfg_data, 32'hC0 + i);
            npu_cfg_rd = 1;
            cycle("t2_pop");
        end
        npu_cfg_rd = 0;
        check_eq("t2_valid_end", {31'd0, npu_cfg_valid}, 32'd0);
        do_reset();

        // 3: wrap the input queue: occupancy swings 0..16..0 twice, then 0..8..0
        begin
            int unsigned wr_n, rd_n, n;
            wr_n = 0; rd_n = 0;
            for (int r = 0; r < 3; r++) begin
                n = (r < 2) ? 16 : 8;
                for (int k = 0; k < n; k++) begin
                    in_enq = 1; in_data = 32'h3000 + wr_n; wr_n++;
                    cycle("t3_push");
                end
                in_enq = 0;
                if (n == 16) check_eq("t3_full", {31'd0, in_full}, 32'd1);
                for (int k = 0; k < n; k++) begin
                    check_eq("t3_data", npu_in_data, 32'h3000 + rd_n); rd_n++;
                    npu_in_rd = 1;
                    cycle("t3_pop");
                end
                npu_in_rd = 0;
            end
        end
        check_eq("t3_err", {29'd0, err}, 32'd0);

        // 4: push+pop on a full output queue
        for (int i = 0; i < 16; i++) begin
            npu_out_wr = 1; npu_out_data = 32'h4000 + i;
            cycle("t4_fill");
        end
        check_eq("t4_full_before", {31'd0, npu_out_full}, 32'd1);
        npu_out_data = 32'h4FFF; out_deq = 1;
        cycle("t4_both");
        idle_inputs();
        check_eq("t4_full_after", {31'd0, npu_out_full}, 32'd0);
        check_eq("t4_err0",       {29'd0, err},          32'd1);
        check_eq("t4_head",       out_data,              32'h4001);
        do_reset();

        // 5: push+pop on an empty input queue
        in_enq = 1; in_data = 32'h55; npu_in_rd = 1;
        cycle("t5_both");
        idle_inputs();
        check_eq("t5_valid", {31'd0, npu_in_valid}, 32'd1);
        check_eq("t5_head",  npu_in_data,           32'h55);
        check_eq("t5_err1",  {29'd0, err},          32'd2);
        do_reset();

        // 6: random concurrent traffic on all three queues
        for (int c = 0; c < 2000; c++) begin
            cfg_enq      = ($urandom_range(0, 99) < 45);
            npu_cfg_rd   = ($urandom_range(0, 99) < 40);
            in_enq       = ($urandom_range(0, 99) < 50);
            npu_in_rd    = ($urandom_range(0, 99) < 50);
            npu_out_wr   = ($urandom_range(0, 99) < 55);
            out_deq      = ($urandom_range(0, 99) < 45);
            cfg_data     = $urandom;
            in_data      = $urandom;
            npu_out_data = $urandom;
            rst_n        = ($urandom_range(0, 499) != 0);
            cycle("t6");
            rst_n = 1;
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
